delay_allocator: RTL and testbench

DELAY_ALLOCATOR -- requirements
Module: delay_allocator

---
 rtl/delay_alloc_pkg.sv | 40 ++++
 rtl/delay_allocator_if.sv | 52 +++++
 rtl/delay_clear_engine.sv | 95 +++++++++
 rtl/delay_allocator.sv | 149 ++++++++++++++
 tb/tb_delay_allocator.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_alloc_pkg.sv
// delay_alloc_pkg: shared definitions for the delay-RAM allocator.
//   HALF          words per pipeline at the default address width
//   clr_state_e   encoding of the RAM clear engine FSM
//   FAIL_*        bit positions of the allocation reject reasons
//   helpers       half_words(), pipe_mask(), idx_width()
package delay_alloc_pkg;

  localparam int DEFAULT_ADDR_W = 16;

  // Each pipeline owns one half of the delay RAM.
  localparam int HALF = 2 ** (DEFAULT_ADDR_W - 1);

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // Reject reasons; a request is rejected when any bit of the vector is set.
  localparam int FAIL_BOTH      = 0;  // both pipelines requested at once
  localparam int FAIL_ZERO      = 1;  // zero-length buffer
  localparam int FAIL_INIT      = 2;  // initial delay not inside the buffer
  localparam int FAIL_SPACE     = 3;  // not enough words left in the half
  localparam int FAIL_COUNT     = 4;  // pipeline already holds MAX_BUFS buffers
  localparam int FAIL_RESETTING = 5;  // pipeline has a clear pending or running
  localparam int FAIL_BUSY      = 6;  // previous request still being evaluated
  localparam int NUM_FAIL       = 7;

  function automatic int half_words(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

  function automatic logic [1:0] pipe_mask(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_allocator_if.sv
// delay_allocator_if: request, result, status and RAM-write signals of the
// delay allocator.
//   master: the controller (drives alloc_req/size/init and full_reset)
//   slave : the allocator   (drives results, status and the RAM write port)
//
// Pulse contract: alloc_req and full_reset are single-cycle pulses with no
// back-pressure. alloc_size/alloc_init are only meaningful in the alloc_req
// cycle. Every accepted alloc_req yields exactly one alloc_done or alloc_fail
// pulse two cycles later, unless a full_reset of the same pipeline aborts it.
// resetting is a level; mem_we is a level, one RAM word per cycle while high.
interface delay_allocator_if
  import delay_alloc_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_BUFS = 16
);
  localparam int IDX_W = idx_width(MAX_BUFS);

  logic [1:0]          alloc_req;
  logic [31:0]         alloc_size;
  logic [31:0]         alloc_init;
  logic [1:0]          full_reset;

  logic [1:0]          resetting;
  logic                alloc_done;
  logic                alloc_fail;
  logic                alloc_pipe;
  logic [IDX_W-1:0]    alloc_index;
  logic [ADDR_W-1:0]   alloc_base;
  logic [ADDR_W-1:0]   alloc_wptr;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [2*ADDR_W-1:0] free_words;
  clr_state_e          clr_state;  // debug view of the clear engine FSM

  modport master (
    output alloc_req, alloc_size, alloc_init, full_reset,
    input  resetting, alloc_done, alloc_fail, alloc_pipe, alloc_index,
           alloc_base, alloc_wptr, mem_we, mem_addr, mem_wdata, free_words,
           clr_state
  );

  modport slave (
    input  alloc_req, alloc_size, alloc_init, full_reset,
    output resetting, alloc_done, alloc_fail, alloc_pipe, alloc_index,
           alloc_base, alloc_wptr, mem_we, mem_addr, mem_wdata, free_words,
           clr_state
  );

endinterface

// File: rtl/delay_clear_engine.sv
// delay_clear_engine: zeroes one pipeline's RAM half, one word per cycle.
//   clk, reset  clock, synchronous active-high reset
//   full_reset  per-pipeline clear request pulses
//   resetting   per-pipeline: clear pending or in progress
//   mem_we/mem_addr/mem_wdata  RAM write port (data always zero)
//   state       current FSM state (debug)
module delay_clear_engine
  import delay_alloc_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        full_reset,
  output logic [1:0]        resetting,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output clr_state_e        state
);

  localparam int OFS_W = ADDR_W - 1;

  clr_state_e       state_q, state_n;
  logic [1:0]       pend_q, pend_n;
  logic             cur_q, cur_n;
  logic [OFS_W-1:0] ofs_q, ofs_n;

  logic [1:0]       restart;
  logic [1:0]       pend_all;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      pend_q  <= 2'b00;
      cur_q   <= 1'b0;
      ofs_q   <= '0;
    end else begin
      state_q <= state_n;
      pend_q  <= pend_n;
      cur_q   <= cur_n;
      ofs_q   <= ofs_n;
    end
  end

  always_comb begin
    // A request for the pipeline being cleared restarts it; any other
    // request joins the pending set, which is consulted in this same cycle
    // so a fresh request starts clearing on the very next cycle.
    restart  = (state_q == CLR_CLEAR) ? (full_reset & pipe_mask(cur_q)) : 2'b00;
    pend_all = pend_q | (full_reset & ~restart);

    state_n = state_q;
    pend_n  = pend_all;
    cur_n   = cur_q;
    ofs_n   = ofs_q;

    case (state_q)
      CLR_IDLE: begin
        if (|pend_all) begin
          state_n = CLR_CLEAR;
          cur_n   = ~pend_all[0];  // pipeline 0 wins a tie
          pend_n  = pend_all & ~pipe_mask(~pend_all[0]);
          ofs_n   = '0;
        end
      end
      CLR_CLEAR: begin
        if (|restart) begin
          ofs_n = '0;
        end else if (ofs_q == '1) begin
          ofs_n = '0;
          if (|pend_all) begin
            cur_n  = ~pend_all[0];
            pend_n = pend_all & ~pipe_mask(~pend_all[0]);
          end else begin
            state_n = CLR_IDLE;
          end
        end else begin
          ofs_n = ofs_q + OFS_W'(1);
        end
      end
      default: begin
        state_n = CLR_IDLE;
      end
    endcase
  end

  assign resetting = pend_q | ((state_q == CLR_CLEAR) ? pipe_mask(cur_q) : 2'b00);
  assign mem_we    = (state_q == CLR_CLEAR);
  assign mem_addr  = {cur_q, ofs_q};
  assign mem_wdata = '0;
  assign state     = state_q;

endmodule

// File: rtl/delay_allocator.sv
// delay_allocator: bump-pointer allocator of delay buffers in a RAM split
// between two pipelines, plus the RAM clear engine.
//   clk, reset  clock, synchronous active-high reset
//   bus         delay_allocator_if.slave: alloc_req/size/init, full_reset in;
//               alloc_done/fail/pipe/index/base/wptr, resetting, free_words,
//               mem_we/addr/wdata, clr_state out
// A request is captured into a one-entry stage, judged in the next cycle,
// and its result registered, so results appear two cycles after alloc_req.
module delay_allocator
  import delay_alloc_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_BUFS = 16
)(
  input  logic clk,
  input  logic reset,
  delay_allocator_if.slave bus
);

  localparam int IDX_W = idx_width(MAX_BUFS);
  localparam int CNT_W = $clog2(MAX_BUFS + 1);
  localparam logic [ADDR_W-1:0] HALF_V = ADDR_W'(half_words(ADDR_W));

  logic [1:0] resetting;

  delay_clear_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_clear (
    .clk        (clk),
    .reset      (reset),
    .full_reset (bus.full_reset),
    .resetting  (resetting),
    .mem_we     (bus.mem_we),
    .mem_addr   (bus.mem_addr),
    .mem_wdata  (bus.mem_wdata),
    .state      (bus.clr_state)
  );

  // Per-pipeline bookkeeping: bump offset within the half and buffer count.
  logic [ADDR_W-1:0] ptr  [2];
  logic [CNT_W-1:0]  cnt  [2];
  logic [ADDR_W-1:0] free [2];

  // Evaluation stage.
  logic [1:0]  st_mask;
  logic        st_busy;
  logic        st_abort;
  logic [31:0] st_size;
  logic [31:0] st_init;
  logic        st_p;

  // Result registers.
  logic              done_q, fail_q, pipe_q;
  logic [IDX_W-1:0]  index_q;
  logic [ADDR_W-1:0] base_q, wptr_q;

  logic [NUM_FAIL-1:0] fail_vec;
  logic                abort;
  logic                accept;
  logic                reject;
  logic [ADDR_W-1:0]   new_base;
  logic [ADDR_W-1:0]   new_wptr;

  assign st_p = (st_mask == 2'b10);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      free[p] = HALF_V - ptr[p];
    end
  end

  always_comb begin
    fail_vec                 = '0;
    fail_vec[FAIL_BOTH]      = (st_mask == 2'b11);
    fail_vec[FAIL_ZERO]      = (st_size == 32'd0);
    fail_vec[FAIL_INIT]      = (st_init >= st_size);
    fail_vec[FAIL_SPACE]     = (st_size > 32'(free[st_p]));
    fail_vec[FAIL_COUNT]     = (cnt[st_p] == CNT_W'(MAX_BUFS));
    fail_vec[FAIL_RESETTING] = resetting[st_p];
    fail_vec[FAIL_BUSY]      = st_busy;

    // A full_reset of the requested pipeline in the capture cycle or in the
    // judging cycle silently drops the request.
    abort  = st_abort | (|(bus.full_reset & st_mask));
    accept = (|st_mask) & ~abort & ~(|fail_vec);
    reject = (|st_mask) & ~abort &  (|fail_vec);

    new_base = {st_p, ptr[st_p][ADDR_W-2:0]};
    new_wptr = new_base + st_init[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_mask  <= 2'b00;
      st_busy  <= 1'b0;
      st_abort <= 1'b0;
      st_size  <= '0;
      st_init  <= '0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      pipe_q   <= 1'b0;
      index_q  <= '0;
      base_q   <= '0;
      wptr_q   <= '0;
      for (int p = 0; p < 2; p++) begin
        ptr[p] <= '0;
        cnt[p] <= '0;
      end
    end else begin
      st_mask  <= bus.alloc_req;
      st_busy  <= |st_mask;
      st_abort <= |(bus.full_reset & bus.alloc_req);
      if (|bus.alloc_req) begin
        st_size <= bus.alloc_size;
        st_init <= bus.alloc_init;
      end

      done_q <= accept;
      fail_q <= reject;
      if (accept || reject) begin
        pipe_q <= st_p;
      end
      if (accept) begin
        index_q <= cnt[st_p][IDX_W-1:0];
        base_q  <= new_base;
        wptr_q  <= new_wptr;
      end

      for (int p = 0; p < 2; p++) begin
        if (bus.full_reset[p]) begin
          ptr[p] <= '0;
          cnt[p] <= '0;
        end else if (accept && (st_p == p[0])) begin
          ptr[p] <= ptr[p] + st_size[ADDR_W-1:0];
          cnt[p] <= cnt[p] + CNT_W'(1);
        end
      end
    end
  end

  assign bus.resetting   = resetting;
  assign bus.alloc_done  = done_q;
  assign bus.alloc_fail  = fail_q;
  assign bus.alloc_pipe  = pipe_q;
  assign bus.alloc_index = index_q;
  assign bus.alloc_base  = base_q;
  assign bus.alloc_wptr  = wptr_q;
  assign bus.free_words  = {free[1], free[0]};

endmodule

// File: tb/tb_delay_allocator.sv
// tb_delay_allocator: directed and randomized checks of delay_allocator
// against a list-of-buffers reference model.
module tb_delay_allocator;
  import delay_alloc_pkg::*;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 16;
  localparam int MAX_BUFS = 16;
  localparam int HALF_N   = 1 << (ADDR_W - 1);
  localparam int RES_W    = 71;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  delay_allocator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BUFS(MAX_BUFS)) bus ();

  delay_allocator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BUFS(MAX_BUFS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  int unsigned sizes_q [2][$];  // lengths of the buffers held by each pipeline
  logic [RES_W-1:0] exp_q[$];
  logic       last_pipe;
  logic [3:0] last_index;
  logic [15:0] last_base, last_wptr;

  function automatic int unsigned model_free(input int p);
    int unsigned used = 0;
    for (int i = 0; i < sizes_q[p].size(); i++) used += sizes_q[p][i];
    return HALF_N - used;
  endfunction

  task automatic model_reset();
    sizes_q[0].delete();
    sizes_q[1].delete();
    last_pipe  = 1'b0;
    last_index = '0;
    last_base  = '0;
    last_wptr  = '0;
  endtask

  task automatic predict(input logic [1:0] mask, input int unsigned size,
                         input int unsigned init, input bit busy,
                         input logic [1:0] clearing);
    int p;
    bit fail;
    int unsigned fr;
    p  = (mask == 2'b10) ? 1 : 0;
    fr = model_free(p);
    fail = (mask == 2'b11) || (size == 0) || (init >= size) || (size > fr) ||
           (sizes_q[p].size() == MAX_BUFS) || clearing[p] || busy;
    last_pipe = p[0];
    if (!fail) begin
      int unsigned base;
      base       = p * HALF_N + (HALF_N - fr);
      last_index = 4'(sizes_q[p].size());
      last_base  = 16'(base);
      last_wptr  = 16'(base + init);
      sizes_q[p].push_back(size);
    end
    exp_q.push_back({~fail, fail, last_pipe, last_index, last_base, last_wptr,
                     16'(model_free(1)), 16'(model_free(0))});
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [RES_W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".done"},  bus.alloc_done,  e[70]);
    chk({tag, ".fail"},  bus.alloc_fail,  e[69]);
    chk({tag, ".pipe"},  bus.alloc_pipe,  e[68]);
    chk({tag, ".index"}, bus.alloc_index, e[67:64]);
    chk({tag, ".base"},  bus.alloc_base,  e[63:48]);
    chk({tag, ".wptr"},  bus.alloc_wptr,  e[47:32]);
    chk({tag, ".free"},  bus.free_words,  e[31:0]);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic alloc_check(input logic [1:0] mask, input int unsigned size,
                             input int unsigned init, input logic [1:0] clearing,
                             input string tag);
    predict(mask, size, init, 1'b0, clearing);
    bus.alloc_req  = mask;
    bus.alloc_size = size;
    bus.alloc_init = init;
    @(negedge clk);
    bus.alloc_req = 2'b00;
    chk({tag, ".early"}, {bus.alloc_done, bus.alloc_fail}, 2'b00);
    @(negedge clk);
    check_result(tag);
  endtask

  task automatic pulse_full_reset(input logic [1:0] mask);
    bus.full_reset = mask;
    @(negedge clk);
    bus.full_reset = 2'b00;
  endtask

  // ---------------- RAM write monitor ----------------
  bit mon_en = 0;
  int wr_count = 0;
  int wr_bad = 0;
  bit rs0_hi = 0, rs1_hi = 0, rs0_seen = 0, rs1_seen = 0;
  int rs0_at = -1, rs1_at = -1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.resetting[0]) rs0_hi = 1;
      else if (rs0_hi && !rs0_seen) begin rs0_seen = 1; rs0_at = wr_count; end
      if (bus.resetting[1]) rs1_hi = 1;
      else if (rs1_hi && !rs1_seen) begin rs1_seen = 1; rs1_at = wr_count; end
      if (bus.mem_we) begin
        if (bus.mem_addr !== wr_count[15:0] || bus.mem_wdata !== '0) wr_bad++;
        wr_count++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] mask;
    int unsigned size, init, r;

    reset          = 1'b1;
    bus.alloc_req  = 2'b00;
    bus.alloc_size = '0;
    bus.alloc_init = '0;
    bus.full_reset = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst.resetting", bus.resetting, 2'b00);
    chk("rst.pulses", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    chk("rst.mem_we", bus.mem_we, 1'b0);
    chk("rst.free", bus.free_words, {16'd32768, 16'd32768});
    chk("rst.result", {bus.alloc_pipe, bus.alloc_index, bus.alloc_base, bus.alloc_wptr}, '0);
    chk("rst.clr_state", bus.clr_state, CLR_IDLE);

    // First allocations
    alloc_check(2'b01, 1000, 200, 2'b00, "first");
    chk("first.free0_const", bus.free_words[15:0], 16'd31768);
    chk("first.wptr_const", bus.alloc_wptr, 16'd200);
    alloc_check(2'b01, 500, 0, 2'b00, "second_p0");
    chk("second_p0.base_const", bus.alloc_base, 16'd1000);
    alloc_check(2'b10, 500, 0, 2'b00, "first_p1");
    chk("first_p1.base_const", bus.alloc_base, 16'h8000);

    // Rejected requests
    alloc_check(2'b01, 0, 0, 2'b00, "size_zero");
    alloc_check(2'b01, 100, 100, 2'b00, "init_eq_size");
    alloc_check(2'b10, 32769, 0, 2'b00, "too_big");
    alloc_check(2'b11, 10, 0, 2'b00, "both_pipes");

    // Back-to-back: the second request arrives while the first is judged
    predict(2'b01, 10, 3, 1'b0, 2'b00);
    predict(2'b01, 10, 3, 1'b1, 2'b00);
    bus.alloc_req = 2'b01; bus.alloc_size = 10; bus.alloc_init = 3;
    @(negedge clk);
    chk("busy.early", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    @(negedge clk);
    bus.alloc_req = 2'b00;
    check_result("busy.first");
    @(negedge clk);
    check_result("busy.second");

    // Randomized requests
    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(0, 9);
      mask = (r == 0) ? 2'b11 : ((r < 5) ? 2'b01 : 2'b10);
      size = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40000) : $urandom_range(0, 2000);
      init = $urandom_range(0, size + 1);
      alloc_check(mask, size, init, 2'b00, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Fill pipeline 1 to its buffer limit, then one more
    for (int i = 0; i < MAX_BUFS; i++) begin
      if (sizes_q[1].size() < MAX_BUFS && model_free(1) > 0)
        alloc_check(2'b10, 1, 0, 2'b00, "fill_p1");
    end
    alloc_check(2'b10, 1, 0, 2'b00, "buf17");
    chk("buf17.fail_const", bus.alloc_fail, 1'b1);

    // Clear both halves
    sizes_q[0].delete();
    sizes_q[1].delete();
    mon_en = 1;
    pulse_full_reset(2'b11);
    chk("clr.resetting", bus.resetting, 2'b11);
    chk("clr.free", bus.free_words, {16'd32768, 16'd32768});
    chk("clr.state", bus.clr_state, CLR_CLEAR);
    for (int c = 0; c < 70000 && bus.resetting != 2'b00; c++) @(negedge clk);
    chk("clr.finished", bus.resetting, 2'b00);
    @(negedge clk);
    mon_en = 0;
    chk("clr.writes", wr_count, 65536);
    chk("clr.addr_seq", wr_bad, 0);
    chk("clr.rs0_fall", rs0_at, 32768);
    chk("clr.rs1_fall", rs1_at, 65536);
    chk("clr.idle", {bus.clr_state, bus.mem_we}, {CLR_IDLE, 1'b0});

    // Allocations while pipeline 0 is clearing
    pulse_full_reset(2'b01);
    chk("clr0.resetting", bus.resetting, 2'b01);
    alloc_check(2'b10, 700, 50, 2'b01, "p1_during_clear");
    chk("p1_during_clear.base_const", bus.alloc_base, 16'h8000);
    alloc_check(2'b01, 10, 0, 2'b01, "p0_during_clear");
    chk("clr0.still_writing", {bus.mem_we, bus.mem_addr[15]}, 2'b10);

    // Reset mid-clear and mid-allocation
    bus.alloc_req = 2'b10; bus.alloc_size = 5; bus.alloc_init = 0;
    @(negedge clk);
    bus.alloc_req = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset.pulses", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("midreset.pulses2", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    chk("midreset.resetting", bus.resetting, 2'b00);
    chk("midreset.idle", {bus.clr_state, bus.mem_we}, {CLR_IDLE, 1'b0});
    chk("midreset.free", bus.free_words, {16'd32768, 16'd32768});
    repeat (5) @(negedge clk);
    chk("midreset.quiet", bus.mem_we, 1'b0);

    // full_reset one cycle after alloc_req aborts the request
    bus.alloc_req = 2'b01; bus.alloc_size = 100; bus.alloc_init = 0;
    @(negedge clk);
    bus.alloc_req  = 2'b00;
    bus.full_reset = 2'b01;
    @(negedge clk);
    bus.full_reset = 2'b00;
    chk("abort1.pulses", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    chk("abort1.resetting", bus.resetting, 2'b01);
    @(negedge clk);
    chk("abort1.pulses2", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    chk("abort1.free0", bus.free_words[15:0], 16'd32768);

    // full_reset in the same cycle as alloc_req aborts the request
    bus.alloc_req = 2'b10; bus.alloc_size = 100; bus.alloc_init = 0;
    bus.full_reset = 2'b10;
    @(negedge clk);
    bus.alloc_req  = 2'b00;
    bus.full_reset = 2'b00;
    @(negedge clk);
    chk("abort0.pulses", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    @(negedge clk);
    chk("abort0.pulses2", {bus.alloc_done, bus.alloc_fail}, 2'b00);
    chk("abort0.resetting", bus.resetting, 2'b11);
    chk("abort0.free1", bus.free_words[31:16], 16'd32768);

    chk("sb.drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
